// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// bundle of per-stage enable/flush controls.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MDU_WAIT = 2'd1,
        HZ_REDIRECT = 2'd2,
        HZ_ILLEGAL  = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_bubble;
    } hz_ctrl_t;

    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    localparam hz_ctrl_t CTRL_RUN = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                      id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_bubble: 1'b0};
    // Enables stay high while flushing; the consuming registers give flush priority.
    localparam hz_ctrl_t CTRL_FLUSH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b1, ex_mem_bubble: 1'b0};
    localparam hz_ctrl_t CTRL_MDU_STALL = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                            id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_bubble: 1'b1};
    localparam hz_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                           id_ex_en: 1'b1, id_ex_flush: 1'b1, ex_mem_bubble: 1'b0};

endpackage

// File: rtl/hazard_load_use_detect.sv
// Combinational RAW compare between the ID source registers and a load in EX.
// x0 is never a real destination, so it never produces a hazard.
module hazard_load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_wb_load,
    input  logic [4:0] ex_wb_rd,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_wb_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_wb_rd);
    assign load_use = ex_wb_load && (ex_wb_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use bubbles, mispredict redirect flushes and MUL/DIV
// occupancy stalls, with a watchdog on the MDU wait and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT     = 64,
    parameter int REDIRECT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_wb_load,
    input  logic [4:0]  ex_wb_rd,
    input  logic        ex_mdu_start,
    input  logic        mdu_done,
    input  logic        ex_mispredict,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic [1:0]  hz_state,
    output logic        mdu_timeout,
    output logic [31:0] stall_count
);

    localparam int MCW = $clog2(MDU_TIMEOUT + 1);
    localparam int RCW = $clog2(REDIRECT_CYCLES + 1);
    localparam logic [MCW-1:0] MDU_LIMIT  = MCW'(MDU_TIMEOUT);
    localparam logic [RCW-1:0] REDIR_LAST = RCW'(REDIRECT_CYCLES - 1);

    hz_state_e       state_q, state_d;
    logic [MCW-1:0]  mdu_cnt_q, mdu_cnt_d;
    logic [RCW-1:0]  redir_cnt_q, redir_cnt_d;
    logic            mdu_timeout_q, mdu_timeout_d;
    logic [31:0]     stall_count_q, stall_count_d;
    hz_ctrl_t        ctrl;
    logic            load_use;

    hazard_load_use_detect u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_wb_load  (ex_wb_load),
        .ex_wb_rd    (ex_wb_rd),
        .load_use    (load_use)
    );

    always_comb begin
        ctrl          = CTRL_RUN;
        state_d       = state_q;
        mdu_cnt_d     = mdu_cnt_q;
        redir_cnt_d   = redir_cnt_q;
        mdu_timeout_d = mdu_timeout_q;
        case (state_q)
            HZ_RUN: begin
                if (ex_mispredict) begin
                    ctrl        = CTRL_FLUSH;
                    redir_cnt_d = RCW'(1);
                    if (REDIRECT_CYCLES > 1) state_d = HZ_REDIRECT;
                end else if (ex_mdu_start && !mdu_done) begin
                    ctrl      = CTRL_MDU_STALL;
                    mdu_cnt_d = MCW'(1);
                    state_d   = HZ_MDU_WAIT;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            // EX is frozen here, so mispredict and load-use cannot be acted on.
            HZ_MDU_WAIT: begin
                if (mdu_done) begin
                    state_d = HZ_RUN;
                end else if (mdu_cnt_q == MDU_LIMIT) begin
                    state_d       = HZ_RUN;
                    mdu_timeout_d = 1'b1;
                end else begin
                    ctrl      = CTRL_MDU_STALL;
                    mdu_cnt_d = mdu_cnt_q + 1'b1;
                end
            end
            HZ_REDIRECT: begin
                ctrl        = CTRL_FLUSH;
                redir_cnt_d = redir_cnt_q + 1'b1;
                if (redir_cnt_q == REDIR_LAST) state_d = HZ_RUN;
            end
            default: state_d = HZ_RUN;
        endcase

        stall_count_d = stall_count_q;
        if (!ctrl.pc_en && (stall_count_q != STALL_MAX)) stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HZ_RUN;
            mdu_cnt_q     <= '0;
            redir_cnt_q   <= '0;
            mdu_timeout_q <= 1'b0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            mdu_cnt_q     <= mdu_cnt_d;
            redir_cnt_q   <= redir_cnt_d;
            mdu_timeout_q <= mdu_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_en      = ctrl.id_ex_en;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign hz_state      = state_q;
    assign mdu_timeout   = mdu_timeout_q;
    assign stall_count   = stall_count_q;

endmodule
